// File: rtl/lcd_roi_counter.sv
// lcd_roi_counter: pixel/line position counters, last-line length, frame
// counter and N_WIN independently programmable region-of-interest windows.
// Window bounds are double-buffered: software writes the pending set at any
// time, and the active set used for comparison only changes at frame start.
module lcd_roi_counter #(
    parameter int CNT_W = 12,
    parameter int N_WIN = 2,
    parameter int FRM_W = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               VS,
    input  logic               HS,
    input  logic               WR_EN,
    input  logic [2:0]         WR_WIN,
    input  logic [1:0]         WR_ADDR,
    input  logic [CNT_W-1:0]   WR_DATA,
    output logic [CNT_W-1:0]   H_CNT,
    output logic [CNT_W-1:0]   V_CNT,
    output logic               ACTIV_V,
    output logic [N_WIN-1:0]   ACTIV_C,
    output logic [N_WIN-1:0]   LINE,
    output logic [CNT_W-1:0]   H_TOTAL,
    output logic [FRM_W-1:0]   FRAME_CNT
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [FRM_W-1:0] FRM_ONE = FRM_W'(1);

    localparam logic [1:0] F_H_START = 2'd0;
    localparam logic [1:0] F_H_END   = 2'd1;
    localparam logic [1:0] F_V_START = 2'd2;
    localparam logic [1:0] F_V_END   = 2'd3;

    logic r_hs;
    logic r_vs;
    logic hs_low_seen;
    logic vs_low_seen;
    logic hs_edge;
    logic vs_edge;

    logic [N_WIN-1:0][3:0][CNT_W-1:0] pend_win;
    logic [N_WIN-1:0][3:0][CNT_W-1:0] act_win;
    logic [N_WIN-1:0][3:0][CNT_W-1:0] pend_nxt;

    logic [N_WIN-1:0] inside_p0;
    logic [N_WIN-1:0] border_p0;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
    endfunction

    // A sync held high across reset release must not look like a new edge,
    // so each edge detector is armed only after its input was sampled low.
    assign hs_edge = HS & ~r_hs & hs_low_seen;
    assign vs_edge = VS & ~r_vs & vs_low_seen;

    // Sync input registers and edge-arming flags.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_hs        <= 1'b0;
            r_vs        <= 1'b0;
            hs_low_seen <= 1'b0;
            vs_low_seen <= 1'b0;
        end else begin
            r_hs        <= HS;
            r_vs        <= VS;
            hs_low_seen <= hs_low_seen | ~HS;
            vs_low_seen <= vs_low_seen | ~VS;
        end
    end

    // Pixel counter; on each line start capture the length of the line just ended.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            H_CNT   <= '0;
            H_TOTAL <= '0;
        end else if (hs_edge) begin
            H_CNT   <= '0;
            H_TOTAL <= H_CNT + CNT_ONE;
        end else begin
            H_CNT   <= sat_inc(H_CNT);
        end
    end

    // Line counter; a frame start overrides a coincident line start.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            V_CNT <= '0;
        end else if (vs_edge) begin
            V_CNT <= '0;
        end else if (hs_edge) begin
            V_CNT <= sat_inc(V_CNT);
        end
    end

    // Frame counter, free-running modulo 2^FRM_W.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            FRAME_CNT <= '0;
        end else if (vs_edge) begin
            FRAME_CNT <= FRAME_CNT + FRM_ONE;
        end
    end

    // Registered AND of both syncs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ACTIV_V <= 1'b0;
        end else begin
            ACTIV_V <= HS & VS;
        end
    end

    // Pending bounds with this cycle's write folded in, so a write landing on
    // the frame-start cycle is part of the copy into the active set.
    always_comb begin
        pend_nxt = pend_win;
        if (WR_EN) begin
            for (int w = 0; w < N_WIN; w++) begin
                if (WR_WIN == 3'(w)) begin
                    pend_nxt[w][WR_ADDR] = WR_DATA;
                end
            end
        end
    end

    // Pending bounds follow writes; active bounds reload only at frame start.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pend_win <= '0;
            act_win  <= '0;
        end else begin
            pend_win <= pend_nxt;
            if (vs_edge) begin
                act_win <= pend_nxt;
            end
        end
    end

    // Stage 0: per-window compare against the current counter values.
    for (genvar g = 0; g < N_WIN; g++) begin : g_win
        logic [CNT_W-1:0] h_start;
        logic [CNT_W-1:0] h_end;
        logic [CNT_W-1:0] v_start;
        logic [CNT_W-1:0] v_end;
        logic [CNT_W-1:0] h_last;
        logic [CNT_W-1:0] v_last;
        logic             win_en;
        logic             in_h;
        logic             in_v;

        assign h_start = act_win[g][F_H_START];
        assign h_end   = act_win[g][F_H_END];
        assign v_start = act_win[g][F_V_START];
        assign v_end   = act_win[g][F_V_END];

        // An empty or inverted range disables the window; the end-1 terms
        // are only formed when enabled so a zero end cannot underflow.
        assign win_en = (h_start < h_end) && (v_start < v_end);
        assign h_last = win_en ? (h_end - CNT_ONE) : '0;
        assign v_last = win_en ? (v_end - CNT_ONE) : '0;

        assign in_h = (H_CNT >= h_start) && (H_CNT < h_end);
        assign in_v = (V_CNT >= v_start) && (V_CNT < v_end);

        assign inside_p0[g] = win_en & in_h & in_v;
        assign border_p0[g] = inside_p0[g] &
                              ((H_CNT == h_start) | (H_CNT == h_last) |
                               (V_CNT == v_start) | (V_CNT == v_last));
    end

    // Stage 1: registered window flags, one cycle behind the counters.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ACTIV_C <= '0;
            LINE    <= '0;
        end else begin
            ACTIV_C <= inside_p0;
            LINE    <= border_p0;
        end
    end

endmodule

// File: tb/tb_lcd_roi_counter.sv
// tb_lcd_roi_counter: directed video timing scenarios plus randomized syncs,
// window writes and resets, compared every cycle against a behavioural model.
module tb_lcd_roi_counter;

    localparam int CNT_W = 12;
    localparam int N_WIN = 2;
    localparam int FRM_W = 16;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic               CLK = 1'b0;
    logic               RESET = 1'b1;
    logic               VS = 1'b0;
    logic               HS = 1'b0;
    logic               WR_EN = 1'b0;
    logic [2:0]         WR_WIN = '0;
    logic [1:0]         WR_ADDR = '0;
    logic [CNT_W-1:0]   WR_DATA = '0;
    logic [CNT_W-1:0]   H_CNT;
    logic [CNT_W-1:0]   V_CNT;
    logic               ACTIV_V;
    logic [N_WIN-1:0]   ACTIV_C;
    logic [N_WIN-1:0]   LINE;
    logic [CNT_W-1:0]   H_TOTAL;
    logic [FRM_W-1:0]   FRAME_CNT;

    lcd_roi_counter #(.CNT_W(CNT_W), .N_WIN(N_WIN), .FRM_W(FRM_W)) dut (
        .CLK(CLK), .RESET(RESET), .VS(VS), .HS(HS),
        .WR_EN(WR_EN), .WR_WIN(WR_WIN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .H_CNT(H_CNT), .V_CNT(V_CNT), .ACTIV_V(ACTIV_V), .ACTIV_C(ACTIV_C),
        .LINE(LINE), .H_TOTAL(H_TOTAL), .FRAME_CNT(FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int misc = 0;

    // Behavioural model state
    int m_h, m_v, m_htot, m_frame;
    bit m_prev_hs, m_prev_vs, m_av;
    bit [N_WIN-1:0] m_ac, m_ln;
    int pend[N_WIN][4];
    int act[N_WIN][4];

    // Flag-high cycle counts: 0 ACTIV_C[0], 1 LINE[0], 2 ACTIV_C[1], 3 LINE[1]
    int cnt_dut[4];
    int cnt_mod[4];

    task automatic chk(input string nm, input longint unsigned got, input longint unsigned exp);
        vectors++;
        if (got != exp) begin
            misc++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_h = 0; m_v = 0; m_htot = 0; m_frame = 0;
        // Treat syncs as "already high" so the first edge needs a low sample.
        m_prev_hs = 1'b1; m_prev_vs = 1'b1;
        m_av = 1'b0; m_ac = '0; m_ln = '0;
        for (int w = 0; w < N_WIN; w++)
            for (int f = 0; f < 4; f++) begin
                pend[w][f] = 0;
                act[w][f] = 0;
            end
    endfunction

    function automatic void model_tick();
        bit hs_e, vs_e;
        bit [N_WIN-1:0] nac, nln;
        if (RESET) begin
            model_reset();
            return;
        end
        hs_e = HS && !m_prev_hs;
        vs_e = VS && !m_prev_vs;
        for (int w = 0; w < N_WIN; w++) begin
            int a_hs, a_he, a_vs, a_ve;
            bit on;
            a_hs = act[w][0]; a_he = act[w][1]; a_vs = act[w][2]; a_ve = act[w][3];
            on = (a_hs < a_he) && (a_vs < a_ve) &&
                 (m_h >= a_hs) && (m_h < a_he) && (m_v >= a_vs) && (m_v < a_ve);
            nac[w] = on;
            nln[w] = on && (m_h == a_hs || m_h == a_he - 1 || m_v == a_vs || m_v == a_ve - 1);
        end
        if (hs_e) begin
            m_htot = (m_h + 1) % (MAXC + 1);
            m_h = 0;
        end else if (m_h < MAXC) begin
            m_h++;
        end
        if (vs_e) m_v = 0;
        else if (hs_e && m_v < MAXC) m_v++;
        if (vs_e) m_frame = (m_frame + 1) % (1 << FRM_W);
        if (WR_EN && int'(WR_WIN) < N_WIN) pend[int'(WR_WIN)][int'(WR_ADDR)] = int'(WR_DATA);
        if (vs_e) act = pend;
        m_ac = nac; m_ln = nln;
        m_av = HS && VS;
        m_prev_hs = HS; m_prev_vs = VS;
    endfunction

    task automatic check_all();
        chk("h_cnt", H_CNT, m_h);
        chk("v_cnt", V_CNT, m_v);
        chk("h_total", H_TOTAL, m_htot);
        chk("frame_cnt", FRAME_CNT, m_frame);
        chk("activ_v", ACTIV_V, m_av);
        chk("activ_c", ACTIV_C, m_ac);
        chk("line", LINE, m_ln);
        cnt_dut[0] += int'(ACTIV_C[0]); cnt_dut[1] += int'(LINE[0]);
        cnt_dut[2] += int'(ACTIV_C[1]); cnt_dut[3] += int'(LINE[1]);
        cnt_mod[0] += int'(m_ac[0]); cnt_mod[1] += int'(m_ln[0]);
        cnt_mod[2] += int'(m_ac[1]); cnt_mod[3] += int'(m_ln[1]);
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 4; k++) begin
            cnt_dut[k] = 0;
            cnt_mod[k] = 0;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_tick();
        @(negedge CLK);
        check_all();
    endtask

    task automatic line_run(input int hp, input bit vs, input int from);
        for (int i = from; i < hp; i++) begin
            HS = (i < 4);
            VS = vs;
            step();
            WR_EN = 1'b0;
        end
    endtask

    task automatic wr(input int w, input int a, input int d);
        WR_EN = 1'b1;
        WR_WIN = 3'(w);
        WR_ADDR = 2'(a);
        WR_DATA = CNT_W'(d);
        HS = 1'b0;
        step();
        WR_EN = 1'b0;
    endtask

    task automatic chk_counts(input string nm, input int ac0, input int ln0, input int ac1, input int ln1);
        chk({nm, "_ac0_dut"}, cnt_dut[0], ac0);
        chk({nm, "_ln0_dut"}, cnt_dut[1], ln0);
        chk({nm, "_ac1_dut"}, cnt_dut[2], ac1);
        chk({nm, "_ln1_dut"}, cnt_dut[3], ln1);
        chk({nm, "_ac0_model"}, cnt_mod[0], ac0);
        chk({nm, "_ln0_model"}, cnt_mod[1], ln0);
    endtask

    initial begin
        model_reset();
        clear_counts();
        repeat (2) @(negedge CLK);
        check_all();
        chk("rst_h_cnt", H_CNT, 0);
        chk("rst_v_cnt", V_CNT, 0);
        chk("rst_h_total", H_TOTAL, 0);
        chk("rst_frame", FRAME_CNT, 0);
        chk("rst_activ_c", ACTIV_C, 0);
        chk("rst_line", LINE, 0);

        RESET = 1'b0;
        step();
        step();

        // Full-width lines: 800-clock HS period
        line_run(800, 1'b1, 0);
        line_run(800, 1'b0, 0);
        line_run(800, 1'b0, 0);
        chk("lit_htot_dut", H_TOTAL, 800);
        chk("lit_htot_model", m_htot, 800);
        chk("lit_vcnt_3lines", V_CNT, 2);
        chk("lit_frame_1", FRAME_CNT, 1);

        // Mid-frame writes: window 0 = H 10..20, V 3..7; window 1 empty H range
        wr(0, 0, 10); wr(0, 1, 20); wr(0, 2, 3); wr(0, 3, 7);
        wr(1, 0, 100); wr(1, 1, 100); wr(1, 2, 0); wr(1, 3, 5);
        wr(2, 1, 11);   // out-of-range index, must not touch window 0
        wr(5, 0, 12);   // out-of-range index, must not enable window 1
        clear_counts();
        for (int l = 0; l < 10; l++) line_run(30, 1'b0, 0);
        chk_counts("pre_vs", 0, 0, 0, 0);

        // Next frame picks up the new bounds: 10 cols x 4 rows
        clear_counts();
        line_run(30, 1'b1, 0);
        for (int l = 0; l < 9; l++) line_run(30, 1'b0, 0);
        chk_counts("win_frame", 40, 24, 0, 0);

        // HS held low: pixel counter saturates
        HS = 1'b0; VS = 1'b0;
        repeat (5000) step();
        chk("lit_hsat_dut", H_CNT, MAXC);
        chk("lit_hsat_model", m_h, MAXC);

        // VS and HS rising together, with a write on the same cycle
        clear_counts();
        HS = 1'b1; VS = 1'b1;
        WR_EN = 1'b1; WR_WIN = 3'd0; WR_ADDR = 2'd0; WR_DATA = CNT_W'(12);
        step();
        WR_EN = 1'b0;
        chk("lit_coinc_v", V_CNT, 0);
        chk("lit_coinc_h", H_CNT, 0);
        chk("lit_coinc_frame", FRAME_CNT, 3);
        line_run(30, 1'b1, 1);
        for (int l = 0; l < 9; l++) line_run(30, 1'b0, 0);
        chk_counts("coinc_frame", 32, 20, 0, 0);

        // Reset mid-line with HS high
        HS = 1'b0; VS = 1'b0; step();
        HS = 1'b1; VS = 1'b1; step(); step();
        RESET = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("lit_arst_h", H_CNT, 0);
        chk("lit_arst_frame", FRAME_CNT, 0);
        chk("lit_arst_activ_v", ACTIV_V, 0);
        repeat (3) step();
        RESET = 1'b0;
        repeat (20) step();
        chk("lit_noedge_h", H_CNT, 20);
        chk("lit_noedge_frame", FRAME_CNT, 0);
        HS = 1'b0; VS = 1'b0; step();
        HS = 1'b1; VS = 1'b1; step();
        chk("lit_reedge_h", H_CNT, 0);
        chk("lit_reedge_frame", FRAME_CNT, 1);

        // Randomized timing, writes and occasional resets
        for (int f = 0; f < 40; f++) begin
            int hp, nl, vsoff, hw;
            hp = int'($urandom_range(20, 60));
            nl = int'($urandom_range(4, 12));
            vsoff = int'($urandom_range(0, 3));
            hw = int'($urandom_range(1, 3));
            for (int l = 0; l < nl; l++) begin
                for (int i = 0; i < hp; i++) begin
                    HS = (i < hw);
                    VS = (l == 0) && (i >= vsoff) && (i < vsoff + hp / 2);
                    if ($urandom_range(0, 7) == 0) begin
                        WR_EN = 1'b1;
                        WR_WIN = 3'($urandom_range(0, 7));
                        WR_ADDR = 2'($urandom_range(0, 3));
                        WR_DATA = CNT_W'($urandom_range(0, 40));
                    end else begin
                        WR_EN = 1'b0;
                    end
                    RESET = ($urandom_range(0, 2999) == 0);
                    step();
                end
            end
        end
        RESET = 1'b0;
        WR_EN = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule

// File: doc/lcd_roi_counter.md
LCD_ROI_COUNTER -- requirements
Module: lcd_roi_counter

Interface
REQ-001 Parameter CNT_W, default 12, width of H/V counters and window bounds.
REQ-002 Parameter N_WIN, default 2, number of independent ROI windows (1..8).
REQ-003 Parameter FRM_W, default 16, width of frame counter.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 CLK  in  1  pixel clock, all logic on rising edge.
REQ-006 RESET  in  1  asynchronous active-high reset.
REQ-007 VS  in  1  vertical sync, frame starts on rising edge.
REQ-008 HS  in  1  horizontal sync, line starts on rising edge.
REQ-009 WR_EN  in  1  window-register write strobe, one write per cycle.
REQ-010 WR_WIN  in  3  window index; writes with WR_WIN >= N_WIN SHALL be ignored.
REQ-011 WR_ADDR  in  2  field select: 0 H_START, 1 H_END, 2 V_START, 3 V_END.
REQ-012 WR_DATA  in  CNT_W  field value.
REQ-013 H_CNT  out  CNT_W  pixel index within line.
REQ-014 V_CNT  out  CNT_W  line index within frame.
REQ-015 ACTIV_V  out  1  registered HS & VS.
REQ-016 ACTIV_C  out  N_WIN  per-window inside flag.
REQ-017 LINE  out  N_WIN  per-window border flag.
REQ-018 H_TOTAL  out  CNT_W  length of last complete line in clocks.
REQ-019 FRAME_CNT  out  FRM_W  frames started since reset.

Function
REQ-020 HS and VS SHALL be registered once (rHS, rVS); HS_EDGE = HS & !rHS, VS_EDGE = VS & !rVS.
REQ-021 On HS_EDGE: H_CNT <= 0, H_TOTAL <= H_CNT + 1; otherwise H_CNT increments, saturating at 2^CNT_W-1 (no wrap).
REQ-022 On VS_EDGE: V_CNT <= 0; else on HS_EDGE: V_CNT increments, saturating at 2^CNT_W-1.
REQ-023 VS_EDGE and HS_EDGE in same cycle: V_CNT <= 0 (VS wins), H_CNT <= 0.
REQ-024 On VS_EDGE FRAME_CNT SHALL increment, wrapping modulo 2^FRM_W.
REQ-025 Each window SHALL have a pending register set (written by WR_EN) and an active set; active <= pending on VS_EDGE only.
REQ-026 Write and VS_EDGE in same cycle: the new value SHALL be included in the copy to active.
REQ-027 Window inside = H_START <= H_CNT < H_END and V_START <= V_CNT < V_END, compared against current counter values, result registered (1-cycle lag).
REQ-028 Window with H_START >= H_END or V_START >= V_END is disabled: ACTIV_C and LINE bits SHALL be 0.
REQ-029 LINE bit SHALL be 1 when inside and (H_CNT == H_START or H_CNT == H_END-1 or V_CNT == V_START or V_CNT == V_END-1), registered like ACTIV_C.
REQ-030 Windows SHALL be evaluated independently; overlapping windows may both assert.
REQ-031 Comparisons SHALL be unsigned, CNT_W wide; H_END-1/V_END-1 computed only when the window is enabled.

Reset
REQ-032 While RESET is high all outputs, rHS, rVS, pending and active window registers SHALL be 0 (all windows disabled).
REQ-033 After RESET release with HS or VS already high, no edge SHALL be detected until a low-to-high transition is seen.
REQ-034 RESET mid-frame SHALL clear state immediately; next VS_EDGE starts FRAME_CNT at 1.

Verification
REQ-035 HS period 800 clocks, VS every 525 lines -> H_TOTAL = 800, V_CNT spans 0..524, FRAME_CNT increments once per frame.
REQ-036 Write window 0 = H 350..550, V 150..350 mid-frame -> no ACTIV_C until next VS_EDGE; then ACTIV_C[0] high for H 350..549, V 150..349, LINE[0] on rows 150/349 and columns 350/549.
REQ-037 Window 1 with H_START = H_END = 100 -> ACTIV_C[1] and LINE[1] stay 0 all frame.
REQ-038 HS held low 5000 clocks with CNT_W = 12 -> H_CNT saturates at 4095, no wrap.
REQ-039 VS and HS rising in same cycle -> V_CNT = 0, H_CNT = 0, FRAME_CNT + 1.
REQ-040 RESET asserted mid-line with HS high -> all outputs 0 in same cycle; after release no HS_EDGE until HS toggles low then high.
